// File: rtl/harq_llr_combine_if.sv
// Bus bundle for the HARQ LLR combiner: block control, rate-dematcher
// stream, and the HARQ buffer read/write ports.
interface harq_llr_combine_if #(
    parameter int WORD_LLRS = 16,
    parameter int LLR_W     = 6
);
    localparam int DW = WORD_LLRS * LLR_W;

    logic            i_Combine_Start;
    logic [15:0]     i_Combine_Ncb_Size;
    logic            i_First_Transmission;
    logic            o_RDM_Data_Request;
    logic [DW-1:0]   i_RDM_Data;
    logic            i_RDM_Data_Valid;
    logic            o_HARQ_Rd_En;
    logic [11:0]     o_HARQ_Rd_Addr;
    logic [DW-1:0]   i_HARQ_Rd_Data;
    logic            o_HARQ_Wr_En;
    logic [11:0]     o_HARQ_Wr_Addr;
    logic [DW-1:0]   o_HARQ_Wr_Data;
    logic            o_Busy;
    logic            o_Combine_Done;

    // Controller / data source / HARQ buffer side
    modport master (
        output i_Combine_Start, i_Combine_Ncb_Size, i_First_Transmission,
        output i_RDM_Data, i_RDM_Data_Valid, i_HARQ_Rd_Data,
        input  o_RDM_Data_Request, o_HARQ_Rd_En, o_HARQ_Rd_Addr,
        input  o_HARQ_Wr_En, o_HARQ_Wr_Addr, o_HARQ_Wr_Data,
        input  o_Busy, o_Combine_Done
    );

    // Combiner side
    modport slave (
        input  i_Combine_Start, i_Combine_Ncb_Size, i_First_Transmission,
        input  i_RDM_Data, i_RDM_Data_Valid, i_HARQ_Rd_Data,
        output o_RDM_Data_Request, o_HARQ_Rd_En, o_HARQ_Rd_Addr,
        output o_HARQ_Wr_En, o_HARQ_Wr_Addr, o_HARQ_Wr_Data,
        output o_Busy, o_Combine_Done
    );
endinterface

// File: rtl/harq_llr_combine.sv
// HARQ soft-combiner: each accepted rate-dematched word is either written
// straight to the HARQ buffer (first transmission) or added lane-wise to the
// stored word with saturation. Three-stage pipeline: accept -> read -> write.
module harq_llr_combine #(
    parameter int WORD_LLRS = 16,
    parameter int LLR_W     = 6
) (
    input  logic               i_core_clk,
    input  logic               i_rx_rst,
    harq_llr_combine_if.slave  bus
);
    localparam int DW = WORD_LLRS * LLR_W;
    // Symmetric saturation range, e.g. [-31,+31] for 6-bit lanes
    localparam logic signed [LLR_W:0] SAT_MAX = (LLR_W+1)'((1 << (LLR_W-1)) - 1);
    localparam logic signed [LLR_W:0] SAT_MIN = -SAT_MAX;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t          state_reg, state_next;
    logic [15:0]     ncb_reg;
    logic            first_reg;
    logic [12:0]     total_reg;
    logic [11:0]     word_cnt_reg;

    logic            s1_valid_reg;
    logic [11:0]     s1_addr_reg;
    logic [DW-1:0]   s1_data_reg;
    logic            rd_en_reg;

    logic            s2_valid_reg;
    logic [11:0]     s2_addr_reg;
    logic [DW-1:0]   s2_data_reg;

    logic            wr_en_reg;
    logic [11:0]     wr_addr_reg;
    logic [DW-1:0]   wr_data_reg;
    logic [DW-1:0]   wr_data_next;

    logic            accept;
    logic            accept_last;
    logic            wr_last;
    logic [12:0]     total_next;

    assign accept      = (state_reg == RUN) && bus.i_RDM_Data_Valid;
    assign accept_last = ({1'b0, word_cnt_reg} == (total_reg - 13'd1));
    assign wr_last     = ({1'b0, wr_addr_reg} == (total_reg - 13'd1));
    // ceil(Ncb/16): whole words plus one if there is a partial tail
    assign total_next  = {1'b0, bus.i_Combine_Ncb_Size[15:4]}
                       + {12'd0, |bus.i_Combine_Ncb_Size[3:0]};

    // State register
    always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
        if (i_rx_rst) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    // Next-state logic; start is only honoured in IDLE
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (bus.i_Combine_Start)
                       state_next = (bus.i_Combine_Ncb_Size == 16'd0) ? DONE : RUN;
            RUN:   if (accept && accept_last) state_next = FLUSH;
            FLUSH: if (wr_en_reg && wr_last)  state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Block parameters latched at start, word counter advanced per acceptance
    always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
        if (i_rx_rst) begin
            ncb_reg      <= '0;
            first_reg    <= 1'b0;
            total_reg    <= '0;
            word_cnt_reg <= '0;
        end else if (state_reg == IDLE && bus.i_Combine_Start) begin
            ncb_reg      <= bus.i_Combine_Ncb_Size;
            first_reg    <= bus.i_First_Transmission;
            total_reg    <= total_next;
            word_cnt_reg <= '0;
        end else if (accept) begin
            word_cnt_reg <= word_cnt_reg + 12'd1;
        end
    end

    // Stage 1: hold the accepted word and issue the HARQ read when combining
    always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
        if (i_rx_rst) begin
            s1_valid_reg <= 1'b0;
            rd_en_reg    <= 1'b0;
            s1_addr_reg  <= '0;
            s1_data_reg  <= '0;
        end else begin
            s1_valid_reg <= accept;
            rd_en_reg    <= accept && !first_reg;
            if (accept) begin
                s1_addr_reg <= word_cnt_reg;
                s1_data_reg <= bus.i_RDM_Data;
            end
        end
    end

    // Stage 2: align the word with the HARQ read data returning this cycle
    always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
        if (i_rx_rst) begin
            s2_valid_reg <= 1'b0;
            s2_addr_reg  <= '0;
            s2_data_reg  <= '0;
        end else begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_addr_reg <= s1_addr_reg;
                s2_data_reg <= s1_data_reg;
            end
        end
    end

    // Per-lane combine: saturating add, or pass-through on first transmission.
    // Lanes beyond Ncb keep the stored value (combine) or are zeroed (first).
    genvar gi;
    generate
        for (gi = 0; gi < WORD_LLRS; gi++) begin : g_lane
            logic signed [LLR_W-1:0] rdm_l, harq_l, sat_l, res_l;
            logic signed [LLR_W:0]   sum_l;
            logic                    in_cb;

            assign rdm_l  = s2_data_reg[gi*LLR_W +: LLR_W];
            assign harq_l = bus.i_HARQ_Rd_Data[gi*LLR_W +: LLR_W];
            assign sum_l  = {rdm_l[LLR_W-1], rdm_l} + {harq_l[LLR_W-1], harq_l};
            assign sat_l  = (sum_l > SAT_MAX) ? SAT_MAX[LLR_W-1:0] :
                            (sum_l < SAT_MIN) ? SAT_MIN[LLR_W-1:0] :
                                                sum_l[LLR_W-1:0];
            assign in_cb  = ({s2_addr_reg, 4'(gi)} < ncb_reg);
            assign res_l  = first_reg ? (in_cb ? rdm_l : '0)
                                      : (in_cb ? sat_l : harq_l);
            assign wr_data_next[gi*LLR_W +: LLR_W] = res_l;
        end
    endgenerate

    // Stage 3: registered HARQ write
    always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
        if (i_rx_rst) begin
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
        end else begin
            wr_en_reg <= s2_valid_reg;
            if (s2_valid_reg) begin
                wr_addr_reg <= s2_addr_reg;
                wr_data_reg <= wr_data_next;
            end
        end
    end

    assign bus.o_RDM_Data_Request = (state_reg == RUN);
    assign bus.o_Busy             = (state_reg != IDLE);
    assign bus.o_Combine_Done     = (state_reg == DONE);
    assign bus.o_HARQ_Rd_En       = rd_en_reg;
    assign bus.o_HARQ_Rd_Addr     = s1_addr_reg;
    assign bus.o_HARQ_Wr_En       = wr_en_reg;
    assign bus.o_HARQ_Wr_Addr     = wr_addr_reg;
    assign bus.o_HARQ_Wr_Data     = wr_data_reg;
endmodule

// File: tb/tb_harq_llr_combine.sv
// Directed bench for harq_llr_combine: HARQ buffer responder, event monitor
// and hand-computed expected words per scenario.
module tb_harq_llr_combine;
    logic        tb_sclk = 1'b0;
    logic        rst     = 1'b1;
    int          cyc     = 0;
    int          n_vec   = 0;
    int          n_err   = 0;
    int          start_cyc = 0;
    int          req_cnt = 0;
    int          busy_cnt = 0;
    logic [95:0] tb_mem [0:15];
    logic [95:0] exp_w  [0:15];
    int          acc_q[$], rd_cyc_q[$], rd_addr_q[$], wr_cyc_q[$], wr_addr_q[$], done_q[$];
    logic [95:0] wr_data_q[$];

    harq_llr_combine_if #(.WORD_LLRS(16), .LLR_W(6)) bus ();

    harq_llr_combine #(.WORD_LLRS(16), .LLR_W(6)) dut (
        .i_core_clk (tb_sclk),
        .i_rx_rst   (rst),
        .bus        (bus)
    );

    always #5 tb_sclk = ~tb_sclk;
    always @(posedge tb_sclk) cyc <= cyc + 1;

    // HARQ buffer model: data returned one cycle after the read strobe
    always @(posedge tb_sclk)
        if (bus.o_HARQ_Rd_En) bus.i_HARQ_Rd_Data <= tb_mem[bus.o_HARQ_Rd_Addr[3:0]];

    // Event monitor, sampled mid-cycle
    always @(negedge tb_sclk) begin
        if (bus.o_RDM_Data_Request) req_cnt++;
        if (bus.o_Busy) busy_cnt++;
        if (bus.o_RDM_Data_Request && bus.i_RDM_Data_Valid) acc_q.push_back(cyc);
        if (bus.o_HARQ_Rd_En) begin
            rd_cyc_q.push_back(cyc);
            rd_addr_q.push_back(int'(bus.o_HARQ_Rd_Addr));
        end
        if (bus.o_HARQ_Wr_En) begin
            wr_cyc_q.push_back(cyc);
            wr_addr_q.push_back(int'(bus.o_HARQ_Wr_Addr));
            wr_data_q.push_back(bus.o_HARQ_Wr_Data);
            $display("wr   cyc=%0d addr=%0d data=%h", cyc, bus.o_HARQ_Wr_Addr, bus.o_HARQ_Wr_Data);
        end
        if (bus.o_Combine_Done) begin
            done_q.push_back(cyc);
            $display("done cyc=%0d", cyc);
        end
    end

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [95:0] fill(input logic [5:0] v);
        logic [95:0] w;
        for (int j = 0; j < 16; j++) w[j*6 +: 6] = v;
        return w;
    endfunction

    function automatic logic [95:0] ramp();
        logic [95:0] w;
        for (int j = 0; j < 16; j++) w[j*6 +: 6] = 6'(j);
        return w;
    endfunction

    task automatic clear_logs();
        acc_q.delete(); rd_cyc_q.delete(); rd_addr_q.delete();
        wr_cyc_q.delete(); wr_addr_q.delete(); wr_data_q.delete(); done_q.delete();
        req_cnt = 0; busy_cnt = 0;
    endtask

    task automatic set_mem(input logic [5:0] v);
        for (int i = 0; i < 16; i++) tb_mem[i] = fill(v);
    endtask

    task automatic start_block(input logic [15:0] ncb, input bit first);
        bus.i_Combine_Start      = 1'b1;
        bus.i_Combine_Ncb_Size   = ncb;
        bus.i_First_Transmission = first;
        start_cyc = cyc;
        @(posedge tb_sclk); #1;
        bus.i_Combine_Start = 1'b0;
    endtask

    // Offer nw words (mode 1 = lane-index ramp, else all lanes v)
    task automatic feed(input int nw, input int mode, input logic [5:0] v,
                        input bit gappy, input bit expect_end);
        int k = 0;
        int guard = 0;
        bit ph = 1'b0;
        while (k < nw && guard < 100) begin
            bus.i_RDM_Data_Valid = gappy ? ~ph : 1'b1;
            bus.i_RDM_Data       = (mode == 1) ? ramp() : fill(v);
            @(negedge tb_sclk);
            if (bus.i_RDM_Data_Valid && bus.o_RDM_Data_Request) k++;
            ph = ~ph;
            guard++;
            @(posedge tb_sclk); #1;
        end
        bus.i_RDM_Data_Valid = 1'b0;
        chk("words_accepted", k, nw);
        if (expect_end) begin
            @(negedge tb_sclk);
            chk("req_low_after_last", bus.o_RDM_Data_Request, 1'b0);
            @(posedge tb_sclk); #1;
        end
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_q.size() == 0 && n < budget) begin
            @(posedge tb_sclk); #1;
            n++;
        end
        chk("done_seen", done_q.size() > 0, 1'b1);
        repeat (4) @(posedge tb_sclk);
        #1;
    endtask

    task automatic check_block(input string nm, input int nw, input bit combine);
        chk({nm, "_nwr"}, wr_cyc_q.size(), nw);
        chk({nm, "_nrd"}, rd_cyc_q.size(), combine ? nw : 0);
        chk({nm, "_nacc"}, acc_q.size(), nw);
        if (acc_q.size() > 0) chk({nm, "_first_acc_cyc"}, acc_q[0], start_cyc + 1);
        for (int k = 0; k < nw && k < wr_cyc_q.size(); k++) begin
            chk($sformatf("%s_wr_addr[%0d]", nm, k), wr_addr_q[k], k);
            chk($sformatf("%s_wr_data[%0d]", nm, k), wr_data_q[k], exp_w[k]);
            if (k < acc_q.size())
                chk($sformatf("%s_wr_lat[%0d]", nm, k), wr_cyc_q[k], acc_q[k] + 3);
        end
        for (int k = 0; combine && k < nw && k < rd_cyc_q.size(); k++) begin
            chk($sformatf("%s_rd_addr[%0d]", nm, k), rd_addr_q[k], k);
            if (k < acc_q.size())
                chk($sformatf("%s_rd_lat[%0d]", nm, k), rd_cyc_q[k], acc_q[k] + 1);
        end
        chk({nm, "_ndone"}, done_q.size(), 1);
        if (done_q.size() > 0 && wr_cyc_q.size() > 0)
            chk({nm, "_done_cyc"}, done_q[0], wr_cyc_q[wr_cyc_q.size()-1] + 1);
    endtask

    task automatic chk_outputs_zero(input string nm);
        chk({nm, "_req"},     bus.o_RDM_Data_Request, 1'b0);
        chk({nm, "_rd_en"},   bus.o_HARQ_Rd_En,       1'b0);
        chk({nm, "_rd_addr"}, bus.o_HARQ_Rd_Addr,     12'd0);
        chk({nm, "_wr_en"},   bus.o_HARQ_Wr_En,       1'b0);
        chk({nm, "_wr_addr"}, bus.o_HARQ_Wr_Addr,     12'd0);
        chk({nm, "_wr_data"}, bus.o_HARQ_Wr_Data,     96'd0);
        chk({nm, "_busy"},    bus.o_Busy,             1'b0);
        chk({nm, "_done"},    bus.o_Combine_Done,     1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_Combine_Start      = 1'b0;
        bus.i_Combine_Ncb_Size   = 16'd0;
        bus.i_First_Transmission = 1'b0;
        bus.i_RDM_Data           = '0;
        bus.i_RDM_Data_Valid     = 1'b0;
        set_mem(6'd0);

        // Reset state
        repeat (2) @(posedge tb_sclk);
        #1;
        chk_outputs_zero("reset");
        rst = 1'b0;
        repeat (2) @(posedge tb_sclk);
        #1;

        // S1: Ncb=32 combine, +20 + +20 saturates to +31; stray start in FLUSH ignored
        clear_logs(); set_mem(6'd20);
        for (int k = 0; k < 2; k++) exp_w[k] = fill(6'd31);
        start_block(16'd32, 1'b0);
        feed(2, 0, 6'd20, 1'b0, 1'b1);
        bus.i_Combine_Start = 1'b1;
        bus.i_Combine_Ncb_Size = 16'd0;
        @(posedge tb_sclk); #1;
        bus.i_Combine_Start = 1'b0;
        wait_done(40);
        check_block("s1", 2, 1'b1);

        // S2: Ncb=110 first transmission, ramp data, tail lanes 14..15 zeroed
        clear_logs(); set_mem(6'd5);
        for (int k = 0; k < 7; k++) exp_w[k] = ramp();
        exp_w[6][95:84] = 12'd0;
        start_block(16'd110, 1'b1);
        feed(7, 1, 6'd0, 1'b0, 1'b1);
        wait_done(40);
        check_block("s2", 7, 1'b0);

        // S3: Ncb=129 combine, -1 + -30 = -31; last word keeps HARQ beyond lane 0
        clear_logs(); set_mem(6'h22);
        for (int k = 0; k < 8; k++) exp_w[k] = fill(6'h21);
        exp_w[8] = fill(6'h22);
        exp_w[8][5:0] = 6'h21;
        start_block(16'd129, 1'b0);
        feed(9, 0, 6'h3F, 1'b0, 1'b1);
        wait_done(40);
        check_block("s3", 9, 1'b1);

        // S4: Ncb=64 combine, valid 1,0,1,0..; HARQ word k holds k+1, RDM 3
        clear_logs();
        for (int k = 0; k < 16; k++) tb_mem[k] = fill(6'(k + 1));
        for (int k = 0; k < 4; k++) exp_w[k] = fill(6'(k + 4));
        start_block(16'd64, 1'b0);
        feed(4, 0, 6'd3, 1'b1, 1'b1);
        wait_done(40);
        check_block("s4", 4, 1'b1);
        for (int k = 1; k < 4 && k < acc_q.size(); k++)
            chk($sformatf("s4_acc_gap[%0d]", k), acc_q[k], acc_q[0] + 2 * k);

        // S5: Ncb=0 -> DONE immediately, no traffic
        clear_logs();
        start_block(16'd0, 1'b0);
        repeat (6) @(posedge tb_sclk);
        #1;
        chk("s5_ndone", done_q.size(), 1);
        if (done_q.size() > 0) chk("s5_done_cyc", done_q[0], start_cyc + 1);
        chk("s5_req_cycles", req_cnt, 0);
        chk("s5_busy_cycles", busy_cnt, 1);
        chk("s5_nrd", rd_cyc_q.size(), 0);
        chk("s5_nwr", wr_cyc_q.size(), 0);

        // S6: reset mid-RUN after 2 accepted words aborts the block
        clear_logs(); set_mem(6'd1);
        start_block(16'd64, 1'b0);
        feed(2, 0, 6'd1, 1'b0, 1'b0);
        rst = 1'b1;
        clear_logs();
        #1;
        chk_outputs_zero("s6_rst");
        repeat (2) @(posedge tb_sclk);
        #1;
        rst = 1'b0;
        repeat (8) @(posedge tb_sclk);
        #1;
        chk("s6_nwr_after_rst", wr_cyc_q.size(), 0);
        chk("s6_nrd_after_rst", rd_cyc_q.size(), 0);
        chk("s6_ndone_after_rst", done_q.size(), 0);

        // S6 restart: Ncb=16 combine, -20 + -20 saturates to -31 at addr 0
        clear_logs(); set_mem(6'h2C);
        exp_w[0] = fill(6'h21);
        start_block(16'd16, 1'b0);
        feed(1, 0, 6'h2C, 1'b0, 1'b1);
        wait_done(40);
        check_block("s6", 1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
